// File: rtl/fmap_loader_pkg.sv
// fmap_loader_pkg: shared types and helpers for the feature-map loader.
//   state_t : loader FSM states (IDLE, LOAD, DONE)
//   bank_w  : width of a bank index for a given bank count (minimum 1)
package fmap_loader_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  function automatic int unsigned bank_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fmap_loader_bank_sel.sv
// bank_sel_counter: round-robin bank index with a per-bank address offset.
// The offset advances each time the bank index wraps back to bank 0.
//   clk, rst : clock, synchronous active-high reset
//   clear    : return bank index and offset to 0
//   advance  : step to the next bank
//   bank     : current bank index
//   offset   : current per-bank address offset (wraps modulo 2**address)
//   wrap     : advance while on the last bank
module bank_sel_counter
  import fmap_loader_pkg::*;
#(
  parameter int unsigned ram_num = 3,
  parameter int unsigned address = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          advance,
  output logic [bank_w(ram_num)-1:0]    bank,
  output logic [address-1:0]            offset,
  output logic                          wrap
);

  localparam int unsigned BW = bank_w(ram_num);
  localparam logic [BW-1:0] LAST_BANK = BW'(ram_num - 1);

  assign wrap = advance && (bank == LAST_BANK);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      bank   <= '0;
      offset <= '0;
    end else if (advance) begin
      if (wrap) begin
        bank   <= '0;
        offset <= offset + address'(1);
      end else begin
        bank   <= bank + BW'(1);
      end
    end
  end

endmodule

// File: rtl/fmap_loader.sv
// fmap_loader: streaming loader driving port A of a multi-bank feature-map RAM.
// Word k of a tile goes to bank k mod ram_num at base_addr + k div ram_num.
// Optional feature macro: LOADER_CHECKSUM_EN (adds checksum port and adder).
//   clk, rst        : clock, synchronous active-high reset
//   start           : load command, honoured only in IDLE
//   base_addr       : first per-bank address, latched on start
//   length          : words to load, latched on start
//   in_data/in_valid/in_ready : input word stream
//   wea, ena        : per-bank port-A strobes (one-hot during a write)
//   addra, dina     : per-bank port-A address/data, bank b at slice b
//   busy            : cycle after accepted start through the DONE cycle
//   done            : one-cycle end-of-load pulse, with the final strobe
//   checksum        : modulo-2**width sum of the tile (LOADER_CHECKSUM_EN)
module fmap_loader
  import fmap_loader_pkg::*;
#(
  parameter int unsigned ram_num = 3,
  parameter int unsigned width   = 16,
  parameter int unsigned address = 12,
  parameter int unsigned cnt_w   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [address-1:0]         base_addr,
  input  logic [cnt_w-1:0]           length,
  input  logic [width-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [ram_num-1:0]         wea,
  output logic [ram_num-1:0]         ena,
  output logic [ram_num*address-1:0] addra,
  output logic [ram_num*width-1:0]   dina,
  output logic                       busy,
  output logic                       done
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [width-1:0]           checksum
`endif
);

  localparam int unsigned BW = bank_w(ram_num);

  state_t               state, state_nx;
  logic [address-1:0]   base_r;
  logic [cnt_w-1:0]     len_r;
  logic [cnt_w-1:0]     cnt;
  logic [BW-1:0]        bank;
  logic [address-1:0]   offset;
  logic                 wrap;
  logic                 unused_wrap;
  logic [ram_num-1:0]   strobe;
  logic                 accept;
  logic                 hs;
  logic                 last;

  // in_ready is a registered copy of (state == LOAD), so the handshake
  // can be decoded from state directly.
  assign accept = (state == IDLE) && start;
  assign hs     = (state == LOAD) && in_valid;
  assign last   = hs && (cnt == len_r - cnt_w'(1));

  assign unused_wrap = wrap;
  assign wea = strobe;
  assign ena = strobe;

  bank_sel_counter #(
    .ram_num (ram_num),
    .address (address)
  ) u_bank_sel (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .advance (hs),
    .bank    (bank),
    .offset  (offset),
    .wrap    (wrap)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = (length == '0) ? DONE : LOAD;
      LOAD: if (last)  state_nx = DONE;
      DONE:            state_nx = IDLE;
      default:         state_nx = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up
  // with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      base_r   <= '0;
      len_r    <= '0;
      cnt      <= '0;
    end else begin
      state    <= state_nx;
      in_ready <= (state_nx == LOAD);
      busy     <= (state_nx != IDLE);
      done     <= (state_nx == DONE);
      if (accept) begin
        base_r <= base_addr;
        len_r  <= length;
        cnt    <= '0;
      end else if (hs) begin
        cnt    <= cnt + cnt_w'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      strobe <= '0;
      addra  <= '0;
      dina   <= '0;
    end else begin
      for (int unsigned b = 0; b < ram_num; b++) begin
        strobe[b] <= hs && (bank == BW'(b));
        if (hs && (bank == BW'(b))) begin
          addra[b*address +: address] <= base_r + offset;
          dina[b*width +: width]      <= in_data;
        end
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst || accept) checksum <= '0;
    else if (hs)       checksum <= checksum + in_data;
  end
`endif

endmodule
